ex_stage_pipe: RTL and testbench

Registered execute stage for the RV32 pipeline, the successor to the combinational ex_stage. It keeps the operand forwarding muxes, the ALU and the branch-target adder, and drives registered EX/MEM outputs. It adds an iterative RV32M multiply/divide path with a busy/stall handshake, downstream back-pressure, and a flush.

---
 rtl/ex_stage_pipe_pkg.sv | 45 ++++
 rtl/ex_stage_pipe_alu.sv | 30 +++
 rtl/ex_stage_pipe_md_unit.sv | 95 +++++++++
 rtl/ex_stage_pipe.sv | 154 +++++++++++++++
 tb/tb_ex_stage_pipe.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_stage_pipe_pkg.sv
// Shared definitions for the registered execute stage: ALU / RV32M op codes,
// the stage state encoding and small op-decoding helpers.
package ex_stage_pipe_pkg;

    localparam logic [3:0] ALU_OP_ADD  = 4'd0;
    localparam logic [3:0] ALU_OP_SUB  = 4'd1;
    localparam logic [3:0] ALU_OP_AND  = 4'd2;
    localparam logic [3:0] ALU_OP_OR   = 4'd3;
    localparam logic [3:0] ALU_OP_XOR  = 4'd4;
    localparam logic [3:0] ALU_OP_SLL  = 4'd5;
    localparam logic [3:0] ALU_OP_SRL  = 4'd6;
    localparam logic [3:0] ALU_OP_SRA  = 4'd7;
    localparam logic [3:0] ALU_OP_SLT  = 4'd8;
    localparam logic [3:0] ALU_OP_SLTU = 4'd9;

    // funct3 order, so bit 2 separates multiply from divide
    localparam logic [2:0] MD_OP_MUL    = 3'd0;
    localparam logic [2:0] MD_OP_MULH   = 3'd1;
    localparam logic [2:0] MD_OP_MULHSU = 3'd2;
    localparam logic [2:0] MD_OP_MULHU  = 3'd3;
    localparam logic [2:0] MD_OP_DIV    = 3'd4;
    localparam logic [2:0] MD_OP_DIVU   = 3'd5;
    localparam logic [2:0] MD_OP_REM    = 3'd6;
    localparam logic [2:0] MD_OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } state_e;

    function automatic logic md_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic md_signed_a(input logic [2:0] op);
        return (op == MD_OP_MULH) || (op == MD_OP_MULHSU) ||
               (op == MD_OP_DIV)  || (op == MD_OP_REM);
    endfunction

    function automatic logic md_signed_b(input logic [2:0] op);
        return (op == MD_OP_MULH) || (op == MD_OP_DIV) || (op == MD_OP_REM);
    endfunction

endpackage

// File: rtl/ex_stage_pipe_alu.sv
// Combinational integer ALU used by the execute stage.
module alu
    import ex_stage_pipe_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [3:0]   op,
    output logic [W-1:0] y
);
    localparam int SH = $clog2(W);

    always_comb begin
        y = '0;
        case (op)
            ALU_OP_ADD:  y = a + b;
            ALU_OP_SUB:  y = a - b;
            ALU_OP_AND:  y = a & b;
            ALU_OP_OR:   y = a | b;
            ALU_OP_XOR:  y = a ^ b;
            ALU_OP_SLL:  y = a << b[SH-1:0];
            ALU_OP_SRL:  y = a >> b[SH-1:0];
            ALU_OP_SRA:  y = $signed(a) >>> b[SH-1:0];
            ALU_OP_SLT:  y = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_OP_SLTU: y = {{(W-1){1'b0}}, a < b};
            default:     y = '0;
        endcase
    end
endmodule

// File: rtl/ex_stage_pipe_md_unit.sv
// Iterative RV32M unit: W shift-add multiply or restoring-divide steps on
// operand magnitudes, with the sign fixed up combinationally on the result.
module md_unit
    import ex_stage_pipe_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         kill,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] res
);
    localparam int CNT_W = $clog2(W + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     hi_q, hi_d, lo_q, lo_d, a_q, b_q;
    logic [2:0]       op_q;
    logic             sa_q, sb_q, sa, sb;
    logic [W-1:0]     aMag, bMag, quot, rem;
    logic [W:0]       mulSum, divShift, divDiff;
    logic [2*W-1:0]   prod, prodFix;

    assign sa   = md_signed_a(op) & a[W-1];
    assign sb   = md_signed_b(op) & b[W-1];
    assign aMag = sa ? -a : a;
    assign bMag = sb ? -b : b;

    // hi/lo hold {accumulator, multiplier} or {remainder, quotient}
    always_comb begin
        mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        divShift = {hi_q, lo_q[W-1]};
        divDiff  = divShift - {1'b0, b_q};
        hi_d     = mulSum[W:1];
        lo_d     = {mulSum[0], lo_q[W-1:1]};
        if (md_is_div(op_q)) begin
            if (!divDiff[W]) begin
                hi_d = divDiff[W-1:0];
                lo_d = {lo_q[W-2:0], 1'b1};
            end else begin
                hi_d = divShift[W-1:0];
                lo_d = {lo_q[W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= MD_OP_MUL;
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
        end else if (kill) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= CNT_W'(W);
            hi_q  <= '0;
            lo_q  <= md_is_div(op) ? aMag : bMag;
            a_q   <= aMag;
            b_q   <= bMag;
            op_q  <= op;
            sa_q  <= sa;
            sb_q  <= sb;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    assign done = (cnt_q == CNT_W'(1));

    // A zero divisor leaves remainder = |dividend|, which the sign fix restores
    always_comb begin
        prod    = {hi_q, lo_q};
        prodFix = (sa_q ^ sb_q) ? -prod : prod;
        quot    = (b_q == '0) ? '1 : ((sa_q ^ sb_q) ? -lo_q : lo_q);
        rem     = sa_q ? -hi_q : hi_q;
        case (op_q)
            MD_OP_MUL:                          res = prodFix[W-1:0];
            MD_OP_MULH, MD_OP_MULHSU,
            MD_OP_MULHU:                        res = prodFix[2*W-1:W];
            MD_OP_DIV, MD_OP_DIVU:              res = quot;
            default:                            res = rem;
        endcase
    end
endmodule

// File: rtl/ex_stage_pipe.sv
// Registered RV32 execute stage: forwarding muxes, ALU, branch-target adder
// and an iterative multiply/divide path with busy/stall/flush handshaking.
module ex_stage_pipe
    import ex_stage_pipe_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 10,
    parameter int IMM_SHIFT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 stall_in,
    input  logic                 flush,
    input  logic [ADDR_SIZE-1:0] pc,
    input  logic [WORD_SIZE-1:0] data1,
    input  logic [WORD_SIZE-1:0] mem_forward1,
    input  logic [WORD_SIZE-1:0] wb_forward1,
    input  logic [WORD_SIZE-1:0] data2,
    input  logic [WORD_SIZE-1:0] mem_forward2,
    input  logic [WORD_SIZE-1:0] wb_forward2,
    input  logic [1:0]           sel_forward1,
    input  logic [1:0]           sel_forward2,
    input  logic [WORD_SIZE-1:0] immd,
    input  logic [3:0]           alu_op,
    input  logic                 alu_src,
    input  logic                 branch,
    input  logic                 jump,
    input  logic                 md_en,
    input  logic [2:0]           md_op,
    output logic                 busy,
    output logic                 out_valid,
    output logic [WORD_SIZE-1:0] result,
    output logic [WORD_SIZE-1:0] write_data,
    output logic                 zero,
    output logic [ADDR_SIZE-1:0] branch_target,
    output logic                 branch_q,
    output logic                 jump_q
);
    state_e               state_q, state_d;
    logic [WORD_SIZE-1:0] op1, fwd2, op2, aluY, mdRes;
    logic                 mdDone, accept, mdStart;
    logic [WORD_SIZE-1:0] result_q, wdata_q;
    logic [ADDR_SIZE-1:0] target_q;
    logic                 valid_q, zero_q, br_q, jmp_q;

    always_comb begin
        case (sel_forward1)
            2'b01:   op1 = mem_forward1;
            2'b10:   op1 = wb_forward1;
            default: op1 = data1;
        endcase
        case (sel_forward2)
            2'b01:   fwd2 = mem_forward2;
            2'b10:   fwd2 = wb_forward2;
            default: fwd2 = data2;
        endcase
    end

    assign op2 = alu_src ? immd : fwd2;

    alu #(.W(WORD_SIZE)) u_alu (
        .a  (op1),
        .b  (op2),
        .op (alu_op),
        .y  (aluY)
    );

    md_unit #(.W(WORD_SIZE)) u_md (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mdStart),
        .kill  (flush),
        .op    (md_op),
        .a     (op1),
        .b     (fwd2),
        .done  (mdDone),
        .res   (mdRes)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (mdStart) state_d = MD_RUN;
                MD_RUN:  if (mdDone) state_d = MD_RUN == MD_RUN ? MD_DONE : MD_RUN;
                MD_DONE: if (!stall_in) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy    = (state_q != IDLE) | stall_in;
        accept  = in_valid & ~busy & ~stall_in & ~flush;
        mdStart = accept & md_en;
    end

    // M ops latch their side outputs at accept; the result lands from MD_DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            wdata_q  <= '0;
            target_q <= '0;
            valid_q  <= 1'b0;
            zero_q   <= 1'b0;
            br_q     <= 1'b0;
            jmp_q    <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        wdata_q  <= fwd2;
                        target_q <= pc + ADDR_SIZE'(immd << IMM_SHIFT);
                        br_q     <= branch;
                        jmp_q    <= jump;
                        valid_q  <= ~md_en;
                        if (!md_en) begin
                            result_q <= aluY;
                            zero_q   <= (aluY == '0);
                        end
                    end else if (!stall_in) begin
                        valid_q <= 1'b0;
                    end
                end
                MD_DONE: begin
                    if (!stall_in) begin
                        result_q <= mdRes;
                        zero_q   <= (mdRes == '0);
                        valid_q  <= 1'b1;
                    end
                end
                default: valid_q <= 1'b0;
            endcase
        end
    end

    assign out_valid     = valid_q;
    assign result        = result_q;
    assign write_data    = wdata_q;
    assign zero          = zero_q;
    assign branch_target = target_q;
    assign branch_q      = br_q;
    assign jump_q        = jmp_q;
endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed bench for ex_stage_pipe: a vector table of ALU and RV32M ops plus
// hand-written reset, stall, flush and MD_DONE back-pressure sequences.
module tb_ex_stage_pipe;
    import ex_stage_pipe_pkg::*;

    localparam int W = 32;
    localparam int A = 10;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, stall_in, flush;
    logic [A-1:0] pc;
    logic [W-1:0] data1, mem_forward1, wb_forward1;
    logic [W-1:0] data2, mem_forward2, wb_forward2;
    logic [1:0]   sel_forward1, sel_forward2;
    logic [W-1:0] immd;
    logic [3:0]   alu_op;
    logic         alu_src, branch, jump, md_en;
    logic [2:0]   md_op;
    logic         busy, out_valid, zero, branch_q, jump_q;
    logic [W-1:0] result, write_data;
    logic [A-1:0] branch_target;

    int passCount  = 0;
    int totalCount = 0;

    ex_stage_pipe #(.WORD_SIZE(W), .ADDR_SIZE(A), .IMM_SHIFT(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall_in(stall_in),
        .flush(flush), .pc(pc), .data1(data1), .mem_forward1(mem_forward1),
        .wb_forward1(wb_forward1), .data2(data2), .mem_forward2(mem_forward2),
        .wb_forward2(wb_forward2), .sel_forward1(sel_forward1),
        .sel_forward2(sel_forward2), .immd(immd), .alu_op(alu_op),
        .alu_src(alu_src), .branch(branch), .jump(jump), .md_en(md_en),
        .md_op(md_op), .busy(busy), .out_valid(out_valid), .result(result),
        .write_data(write_data), .zero(zero), .branch_target(branch_target),
        .branch_q(branch_q), .jump_q(jump_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        mdEn;
        logic [3:0]  op;
        logic        aluSrc;
        logic [1:0]  sel1;
        logic [1:0]  sel2;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] expRes;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        totalCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    // Non-selected forwarding sources carry junk so a wrong mux pick shows up
    task automatic applyStimulus(input logic mdEn, input logic [3:0] op,
                                 input logic aluSrc, input logic [1:0] s1,
                                 input logic [1:0] s2, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] imm,
                                 input logic [A-1:0] pcv, input logic br,
                                 input logic jp);
        md_en        = mdEn;
        alu_op       = op;
        md_op        = op[2:0];
        alu_src      = aluSrc;
        sel_forward1 = s1;
        sel_forward2 = s2;
        data1        = (s1 == 2'b00 || s1 == 2'b11) ? a : 32'hDEAD0001;
        mem_forward1 = (s1 == 2'b01) ? a : 32'hDEAD0002;
        wb_forward1  = (s1 == 2'b10) ? a : 32'hDEAD0003;
        data2        = (s2 == 2'b00 || s2 == 2'b11) ? b : 32'hBEEF0001;
        mem_forward2 = (s2 == 2'b01) ? b : 32'hBEEF0002;
        wb_forward2  = (s2 == 2'b10) ? b : 32'hBEEF0003;
        immd         = imm;
        pc           = pcv;
        branch       = br;
        jump         = jp;
        in_valid     = 1'b1;
    endtask

    task automatic waitValid(output int edges, output logic busyHeld);
        edges    = 0;
        busyHeld = 1'b1;
        while (edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            in_valid = 1'b0;
            if (out_valid) break;
            if (!busy) busyHeld = 1'b0;
        end
    endtask

    initial begin
        int   edges;
        logic busyHeld;

        rst_n = 1'b0; in_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
        applyStimulus(1'b0, ALU_OP_ADD, 1'b0, 2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 1'b0);
        in_valid = 1'b0;

        vecs.push_back('{"add",    1'b0, ALU_OP_ADD,  1'b0, 2'b00, 2'b00, 32'd10,      32'd5,       32'd0,    32'd15});
        vecs.push_back('{"subfwd", 1'b0, ALU_OP_SUB,  1'b0, 2'b00, 2'b01, 32'd324,     32'd8,       32'd0,    32'd316});
        vecs.push_back('{"andwb",  1'b0, ALU_OP_AND,  1'b0, 2'b10, 2'b10, 32'h0000F0F0, 32'h00000FF0, 32'd0,  32'h000000F0});
        vecs.push_back('{"orimm",  1'b0, ALU_OP_OR,   1'b1, 2'b01, 2'b00, 32'h00000100, 32'h0000FFFF, 32'h0F, 32'h0000010F});
        vecs.push_back('{"xor11",  1'b0, ALU_OP_XOR,  1'b0, 2'b11, 2'b11, 32'h000000FF, 32'h0000000F, 32'd0,  32'h000000F0});
        vecs.push_back('{"slt",    1'b0, ALU_OP_SLT,  1'b0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1,       32'd0,    32'd1});
        vecs.push_back('{"sltu",   1'b0, ALU_OP_SLTU, 1'b0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1,       32'd0,    32'd0});
        vecs.push_back('{"sra",    1'b0, ALU_OP_SRA,  1'b0, 2'b00, 2'b00, 32'h80000000, 32'd4,       32'd0,    32'hF8000000});
        vecs.push_back('{"subz",   1'b0, ALU_OP_SUB,  1'b0, 2'b00, 2'b00, 32'd5,       32'd5,       32'd0,    32'd0});
        vecs.push_back('{"mul",    1'b1, {1'b0, MD_OP_MUL},    1'b0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'h00000001});
        vecs.push_back('{"mulhu",  1'b1, {1'b0, MD_OP_MULHU},  1'b0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFE});
        vecs.push_back('{"mulh",   1'b1, {1'b0, MD_OP_MULH},   1'b0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'h00000000});
        vecs.push_back('{"mulhsu", 1'b1, {1'b0, MD_OP_MULHSU}, 1'b0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF});
        vecs.push_back('{"mul67",  1'b1, {1'b0, MD_OP_MUL},    1'b1, 2'b01, 2'b10, 32'd6,       32'd7,       32'd99, 32'd42});
        vecs.push_back('{"div",    1'b1, {1'b0, MD_OP_DIV},    1'b0, 2'b00, 2'b00, 32'hFFFFFFF9, 32'd2,       32'd0, 32'hFFFFFFFD});
        vecs.push_back('{"rem",    1'b1, {1'b0, MD_OP_REM},    1'b0, 2'b00, 2'b00, 32'hFFFFFFF9, 32'd2,       32'd0, 32'hFFFFFFFF});
        vecs.push_back('{"div0",   1'b1, {1'b0, MD_OP_DIV},    1'b0, 2'b00, 2'b00, 32'd5,       32'd0,       32'd0, 32'hFFFFFFFF});
        vecs.push_back('{"remu0",  1'b1, {1'b0, MD_OP_REMU},   1'b0, 2'b00, 2'b00, 32'd5,       32'd0,       32'd0, 32'd5});
        vecs.push_back('{"divovf", 1'b1, {1'b0, MD_OP_DIV},    1'b0, 2'b00, 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000});
        vecs.push_back('{"removf", 1'b1, {1'b0, MD_OP_REM},    1'b0, 2'b00, 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h00000000});
        vecs.push_back('{"divu",   1'b1, {1'b0, MD_OP_DIVU},   1'b0, 2'b00, 2'b00, 32'd100,     32'd7,       32'd0, 32'd14});

        // Reset values, then a reset pulled in the middle of an M op
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, {1'b0, MD_OP_MUL}, 1'b0, 2'b00, 2'b00, 32'd3, 32'd9, 32'd16, 10'd100, 1'b1, 1'b1);
        repeat (5) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        checkOutput("mdrun busy", {31'b0, busy}, 32'd1);
        checkOutput("mdrun wdata", write_data, 32'd9);
        rst_n = 1'b0;
        #2;
        checkOutput("midrst busy", {31'b0, busy}, 32'd0);
        checkOutput("midrst out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("midrst result", result, 32'd0);
        checkOutput("midrst wdata", write_data, 32'd0);
        checkOutput("midrst target", {22'b0, branch_target}, 32'd0);
        checkOutput("midrst br/jmp/zero", {29'b0, branch_q, jump_q, zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("postrst busy", {31'b0, busy}, 32'd0);
        checkOutput("postrst out_valid", {31'b0, out_valid}, 32'd0);

        @(negedge clk);
        applyStimulus(1'b0, ALU_OP_ADD, 1'b0, 2'b00, 2'b00, 32'd10, 32'd5, 32'd16, 10'd100, 1'b0, 1'b1);
        waitValid(edges, busyHeld);
        checkOutput("add latency", edges, 32'd1);
        checkOutput("add result", result, 32'd15);
        checkOutput("add zero", {31'b0, zero}, 32'd0);
        checkOutput("add target", {22'b0, branch_target}, 32'd164);
        checkOutput("add jump_q", {31'b0, jump_q}, 32'd1);
        checkOutput("add branch_q", {31'b0, branch_q}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("bubble out_valid", {31'b0, out_valid}, 32'd0);

        @(negedge clk);
        applyStimulus(1'b0, ALU_OP_ADD, 1'b0, 2'b00, 2'b00, 32'd1, 32'd1, 32'd2, 10'd1020, 1'b1, 1'b0);
        waitValid(edges, busyHeld);
        checkOutput("wrap target", {22'b0, branch_target}, 32'd4);
        checkOutput("wrap branch_q", {31'b0, branch_q}, 32'd1);

        // Table of single instructions
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].mdEn, vecs[i].op, vecs[i].aluSrc, vecs[i].sel1,
                          vecs[i].sel2, vecs[i].a, vecs[i].b, vecs[i].imm,
                          10'd0, 1'b0, 1'b0);
            waitValid(edges, busyHeld);
            checkOutput({vecs[i].name, " result"}, result, vecs[i].expRes);
            checkOutput({vecs[i].name, " latency"}, edges, vecs[i].mdEn ? 32'd34 : 32'd1);
            checkOutput({vecs[i].name, " zero"}, {31'b0, zero}, {31'b0, vecs[i].expRes == 32'd0});
            checkOutput({vecs[i].name, " wdata"}, write_data, vecs[i].b);
            if (vecs[i].mdEn) begin
                checkOutput({vecs[i].name, " busy held"}, {31'b0, busyHeld}, 32'd1);
                checkOutput({vecs[i].name, " busy after"}, {31'b0, busy}, 32'd0);
            end
        end

        // Downstream stall holds the registered SUB result
        @(negedge clk);
        applyStimulus(1'b0, ALU_OP_SUB, 1'b0, 2'b00, 2'b01, 32'd324, 32'd8, 32'd0, 10'd0, 1'b0, 1'b0);
        waitValid(edges, busyHeld);
        checkOutput("fwd sub result", result, 32'd316);
        stall_in = 1'b1;
        applyStimulus(1'b0, ALU_OP_ADD, 1'b0, 2'b00, 2'b00, 32'd1, 32'd1, 32'd0, 10'd0, 1'b0, 1'b0);
        #1;
        checkOutput("stall busy", {31'b0, busy}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("stall hold result", result, 32'd316);
        checkOutput("stall hold valid", {31'b0, out_valid}, 32'd1);
        checkOutput("stall busy2", {31'b0, busy}, 32'd1);
        stall_in = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("unstall bubble", {31'b0, out_valid}, 32'd0);
        checkOutput("unstall result", result, 32'd316);

        // Flush ten cycles into a divide, then a one-cycle ADD
        @(negedge clk);
        applyStimulus(1'b1, {1'b0, MD_OP_DIV}, 1'b0, 2'b00, 2'b00, 32'd100, 32'd7, 32'd0, 10'd0, 1'b0, 1'b0);
        repeat (10) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        checkOutput("preflush busy", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("flush busy", {31'b0, busy}, 32'd0);
        applyStimulus(1'b0, ALU_OP_ADD, 1'b0, 2'b00, 2'b00, 32'd3, 32'd4, 32'd0, 10'd0, 1'b0, 1'b0);
        waitValid(edges, busyHeld);
        checkOutput("postflush latency", edges, 32'd1);
        checkOutput("postflush result", result, 32'd7);

        // Back-pressure while the divide result is waiting in MD_DONE
        @(negedge clk);
        applyStimulus(1'b1, {1'b0, MD_OP_DIVU}, 1'b0, 2'b00, 2'b00, 32'd100, 32'd7, 32'd0, 10'd0, 1'b0, 1'b0);
        repeat (33) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        checkOutput("mddone entry busy", {31'b0, busy}, 32'd1);
        stall_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("mddone stall%0d valid", k), {31'b0, out_valid}, 32'd0);
            checkOutput($sformatf("mddone stall%0d busy", k), {31'b0, busy}, 32'd1);
        end
        stall_in = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mddone release valid", {31'b0, out_valid}, 32'd1);
        checkOutput("mddone release result", result, 32'd14);
        checkOutput("mddone release busy", {31'b0, busy}, 32'd0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end
endmodule
